// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS control FSM
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_R_EXEC    = 4'd2,
    S_R_WB      = 4'd3,
    S_I_EXEC    = 4'd4,
    S_I_WB      = 4'd5,
    S_MEM_ADDR  = 4'd6,
    S_MEM_READ  = 4'd7,
    S_MEM_WB    = 4'd8,
    S_MEM_WRITE = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_JAL       = 4'd12,
    S_JR        = 4'd13,
    S_TRAP      = 4'd14
  } state_e;

  typedef enum logic [2:0] {
    CLS_R, CLS_JR, CLS_MEM, CLS_BR, CLS_I, CLS_J, CLS_JAL, CLS_ILL
  } instr_class_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLE   = 6'b000110;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LI    = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FUNC_JR  = 6'b001000;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_BEQ   = 4'b0001;
  localparam logic [3:0] ALU_R     = 4'b0010;
  localparam logic [3:0] ALU_BNE   = 4'b0011;
  localparam logic [3:0] ALU_ORI   = 4'b0100;
  localparam logic [3:0] ALU_LW    = 4'b0101;
  localparam logic [3:0] ALU_SLTIU = 4'b0110;
  localparam logic [3:0] ALU_SW    = 4'b0111;
  localparam logic [3:0] ALU_BLE   = 4'b1000;
  localparam logic [3:0] ALU_JAL   = 4'b1001;
  localparam logic [3:0] ALU_BLTZ  = 4'b1010;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;
  localparam logic [1:0] PCS_REGA   = 2'd3;

  localparam logic [1:0] ASB_REGB  = 2'd0;
  localparam logic [1:0] ASB_FOUR  = 2'd1;
  localparam logic [1:0] ASB_IMM   = 2'd2;
  localparam logic [1:0] ASB_BRIMM = 2'd3;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  localparam logic [1:0] BT_BEQ  = 2'd0;
  localparam logic [1:0] BT_BLE  = 2'd1;
  localparam logic [1:0] BT_BLTZ = 2'd2;
  localparam logic [1:0] BT_BNE  = 2'd3;

endpackage

// File: rtl/mc_ctrl_opdecode.sv
// rtl/mc_ctrl_opdecode.sv - maps opcode/func to instruction class, execute ALU op and branch type
module mc_ctrl_opdecode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]   op_i,
  input  logic [5:0]   func_i,
  output instr_class_e class_o,
  output logic [3:0]   alu_op_o,
  output logic [1:0]   branch_type_o,
  output logic         is_store_o,
  output logic         illegal_o
);

  always_comb begin
    class_o       = CLS_ILL;
    alu_op_o      = ALU_ADD;
    branch_type_o = BT_BEQ;
    is_store_o    = 1'b0;
    case (op_i)
      OP_RTYPE: begin
        if (func_i == FUNC_JR) begin
          class_o = CLS_JR;
        end else begin
          class_o  = CLS_R;
          alu_op_o = ALU_R;
        end
      end
      OP_LW: begin
        class_o  = CLS_MEM;
        alu_op_o = ALU_LW;
      end
      OP_SW: begin
        class_o    = CLS_MEM;
        alu_op_o   = ALU_SW;
        is_store_o = 1'b1;
      end
      OP_BEQ: begin
        class_o = CLS_BR;
        alu_op_o = ALU_BEQ;
        branch_type_o = BT_BEQ;
      end
      OP_BNE: begin
        class_o = CLS_BR;
        alu_op_o = ALU_BNE;
        branch_type_o = BT_BNE;
      end
      OP_BLE: begin
        class_o = CLS_BR;
        alu_op_o = ALU_BLE;
        branch_type_o = BT_BLE;
      end
      OP_BLTZ: begin
        class_o = CLS_BR;
        alu_op_o = ALU_BLTZ;
        branch_type_o = BT_BLTZ;
      end
      OP_ADDI, OP_LI: class_o = CLS_I;
      OP_SLTIU: begin
        class_o  = CLS_I;
        alu_op_o = ALU_SLTIU;
      end
      OP_ORI: begin
        class_o  = CLS_I;
        alu_op_o = ALU_ORI;
      end
      OP_J:    class_o = CLS_J;
      OP_JAL:  class_o = CLS_JAL;
      default: class_o = CLS_ILL;
    endcase
    illegal_o = (class_o == CLS_ILL);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS control FSM with memory-ready stall and trap
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 0,
  parameter int unsigned WAIT_W       = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] instr_op_i,
  input  logic [5:0] instr_func_i,
  input  logic       mem_ready_i,
  output logic       PCWrite_o,
  output logic       PCWriteCond_o,
  output logic       IorD_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic [1:0] MemtoReg_o,
  output logic [1:0] RegDst_o,
  output logic       RegWrite_o,
  output logic       ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [3:0] ALU_op_o,
  output logic [1:0] PCSource_o,
  output logic [1:0] BranchType_o,
  output logic       instr_done_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic [1:0]        bt_q, bt_d;
  logic              store_q, store_d;

  instr_class_e dec_class;
  logic [3:0]   dec_alu_op;
  logic [1:0]   dec_bt;
  logic         dec_store;
  logic         dec_illegal;

  mc_ctrl_opdecode u_opdecode (
    .op_i          (instr_op_i),
    .func_i        (instr_func_i),
    .class_o       (dec_class),
    .alu_op_o      (dec_alu_op),
    .branch_type_o (dec_bt),
    .is_store_o    (dec_store),
    .illegal_o     (dec_illegal)
  );

  logic mem_wait_st;
  logic wait_expired;

  assign mem_wait_st  = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
  // Trap in the cycle where one more idle cycle would make the counter reach the limit.
  assign wait_expired = (MEM_WAIT_MAX != 0) && ((32'(wait_q) + 32'd1) >= MEM_WAIT_MAX);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_FETCH;
      wait_q   <= '0;
      alu_op_q <= ALU_ADD;
      bt_q     <= BT_BEQ;
      store_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      alu_op_q <= alu_op_d;
      bt_q     <= bt_d;
      store_q  <= store_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    alu_op_d = alu_op_q;
    bt_d     = bt_q;
    store_d  = store_q;
    wait_d   = '0;
    if (mem_wait_st && !mem_ready_i) begin
      wait_d = (&wait_q) ? wait_q : wait_q + 1'b1;
    end

    PCWrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    IorD_o        = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    IRWrite_o     = 1'b0;
    MemtoReg_o    = M2R_ALUOUT;
    RegDst_o      = RD_RT;
    RegWrite_o    = 1'b0;
    ALUSrcA_o     = 1'b0;
    ALUSrcB_o     = ASB_REGB;
    ALU_op_o      = ALU_ADD;
    PCSource_o    = PCS_ALU;
    BranchType_o  = BT_BEQ;
    instr_done_o  = 1'b0;

    case (state_q)
      S_FETCH: begin
        MemRead_o = 1'b1;
        ALUSrcB_o = ASB_FOUR;
        if (mem_ready_i) begin
          IRWrite_o = 1'b1;
          PCWrite_o = 1'b1;
          state_d   = S_DECODE;
        end else if (wait_expired) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        ALUSrcB_o = ASB_BRIMM;
        // Only place the opcode is looked at; later states use the latched copy.
        alu_op_d  = dec_alu_op;
        bt_d      = dec_bt;
        store_d   = dec_store;
        if (dec_illegal) begin
          state_d = S_TRAP;
        end else begin
          case (dec_class)
            CLS_R:   state_d = S_R_EXEC;
            CLS_JR:  state_d = S_JR;
            CLS_MEM: state_d = S_MEM_ADDR;
            CLS_BR:  state_d = S_BRANCH;
            CLS_I:   state_d = S_I_EXEC;
            CLS_J:   state_d = S_JUMP;
            CLS_JAL: state_d = S_JAL;
            default: state_d = S_TRAP;
          endcase
        end
      end
      S_R_EXEC: begin
        ALUSrcA_o = 1'b1;
        ALU_op_o  = ALU_R;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        RegDst_o     = RD_RD;
        RegWrite_o   = 1'b1;
        instr_done_o = 1'b1;
        state_d      = S_FETCH;
      end
      S_I_EXEC: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = ASB_IMM;
        ALU_op_o  = alu_op_q;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        RegWrite_o   = 1'b1;
        instr_done_o = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_ADDR: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = ASB_IMM;
        ALU_op_o  = alu_op_q;
        state_d   = store_q ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        MemRead_o = 1'b1;
        IorD_o    = 1'b1;
        if (mem_ready_i) begin
          state_d = S_MEM_WB;
        end else if (wait_expired) begin
          state_d = S_TRAP;
        end
      end
      S_MEM_WB: begin
        MemtoReg_o   = M2R_MDR;
        RegWrite_o   = 1'b1;
        instr_done_o = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WRITE: begin
        MemWrite_o = 1'b1;
        IorD_o     = 1'b1;
        if (mem_ready_i) begin
          instr_done_o = 1'b1;
          state_d      = S_FETCH;
        end else if (wait_expired) begin
          state_d = S_TRAP;
        end
      end
      S_BRANCH: begin
        ALUSrcA_o     = 1'b1;
        PCWriteCond_o = 1'b1;
        PCSource_o    = PCS_ALUOUT;
        ALU_op_o      = alu_op_q;
        BranchType_o  = bt_q;
        instr_done_o  = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        PCWrite_o    = 1'b1;
        PCSource_o   = PCS_JUMP;
        instr_done_o = 1'b1;
        state_d      = S_FETCH;
      end
      S_JAL: begin
        PCWrite_o    = 1'b1;
        PCSource_o   = PCS_JUMP;
        RegWrite_o   = 1'b1;
        RegDst_o     = RD_RA;
        MemtoReg_o   = M2R_PC;
        ALU_op_o     = ALU_JAL;
        instr_done_o = 1'b1;
        state_d      = S_FETCH;
      end
      S_JR: begin
        PCWrite_o    = 1'b1;
        PCSource_o   = PCS_REGA;
        instr_done_o = 1'b1;
        state_d      = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    // Reset must cut every write immediately, even mid-cycle.
    if (rst_i) begin
      PCWrite_o     = 1'b0;
      PCWriteCond_o = 1'b0;
      IorD_o        = 1'b0;
      MemRead_o     = 1'b0;
      MemWrite_o    = 1'b0;
      IRWrite_o     = 1'b0;
      MemtoReg_o    = M2R_ALUOUT;
      RegDst_o      = RD_RT;
      RegWrite_o    = 1'b0;
      ALUSrcA_o     = 1'b0;
      ALUSrcB_o     = ASB_REGB;
      ALU_op_o      = ALU_ADD;
      PCSource_o    = PCS_ALU;
      BranchType_o  = BT_BEQ;
      instr_done_o  = 1'b0;
    end
  end

  assign illegal_o = (state_q == S_TRAP);
  assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [5:0] instr_op_i;
  logic [5:0] instr_func_i;
  logic       mem_ready_i;
  logic       PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o;
  logic [1:0] MemtoReg_o, RegDst_o, ALUSrcB_o, PCSource_o, BranchType_o;
  logic       RegWrite_o, ALUSrcA_o, instr_done_o, illegal_o;
  logic [3:0] ALU_op_o, state_o;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_WAIT_MAX(4), .WAIT_W(8)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .instr_op_i    (instr_op_i),
    .instr_func_i  (instr_func_i),
    .mem_ready_i   (mem_ready_i),
    .PCWrite_o     (PCWrite_o),
    .PCWriteCond_o (PCWriteCond_o),
    .IorD_o        (IorD_o),
    .MemRead_o     (MemRead_o),
    .MemWrite_o    (MemWrite_o),
    .IRWrite_o     (IRWrite_o),
    .MemtoReg_o    (MemtoReg_o),
    .RegDst_o      (RegDst_o),
    .RegWrite_o    (RegWrite_o),
    .ALUSrcA_o     (ALUSrcA_o),
    .ALUSrcB_o     (ALUSrcB_o),
    .ALU_op_o      (ALU_op_o),
    .PCSource_o    (PCSource_o),
    .BranchType_o  (BranchType_o),
    .instr_done_o  (instr_done_o),
    .illegal_o     (illegal_o),
    .state_o       (state_o)
  );

  typedef struct {
    string name;
    int st, lat, rw, rd, m2r, pcs, bt, pcwc, mw, alu_done, alu_ex, rdc, pcwn;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", n, act, exp);
    end
  endtask

  function automatic exp_t mk(input string n, input int st, input int lat, input int rw,
                              input int rd, input int m2r, input int pcs, input int bt,
                              input int pcwc, input int mw, input int alu_done,
                              input int alu_ex, input int rdc, input int pcwn);
    exp_t e;
    e.name = n; e.st = st; e.lat = lat; e.rw = rw; e.rd = rd; e.m2r = m2r; e.pcs = pcs;
    e.bt = bt; e.pcwc = pcwc; e.mw = mw; e.alu_done = alu_done; e.alu_ex = alu_ex;
    e.rdc = rdc; e.pcwn = pcwn;
    return e;
  endfunction

  // Monitor: accumulate per-instruction activity, compare on instr_done_o.
  int mon_cyc = 0, mon_rdc = 0, mon_pcwn = 0, mon_alu_ex = 0;
  always @(negedge clk) begin
    if (rst_i) begin
      mon_cyc = 0; mon_rdc = 0; mon_pcwn = 0; mon_alu_ex = 0;
    end else begin
      mon_cyc++;
      if (MemRead_o && IorD_o) mon_rdc++;
      if (PCWrite_o) mon_pcwn++;
      if (ALUSrcA_o) mon_alu_ex = int'(ALU_op_o);
      if (instr_done_o) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk({e.name, "_state"},      int'(state_o),       e.st);
          chk({e.name, "_latency"},    mon_cyc,             e.lat);
          chk({e.name, "_RegWrite"},   int'(RegWrite_o),    e.rw);
          chk({e.name, "_RegDst"},     int'(RegDst_o),      e.rd);
          chk({e.name, "_MemtoReg"},   int'(MemtoReg_o),    e.m2r);
          chk({e.name, "_PCSource"},   int'(PCSource_o),    e.pcs);
          chk({e.name, "_BranchType"}, int'(BranchType_o),  e.bt);
          chk({e.name, "_PCWriteCond"},int'(PCWriteCond_o), e.pcwc);
          chk({e.name, "_MemWrite"},   int'(MemWrite_o),    e.mw);
          chk({e.name, "_ALU_op"},     int'(ALU_op_o),      e.alu_done);
          chk({e.name, "_exec_alu"},   mon_alu_ex,          e.alu_ex);
          chk({e.name, "_memrd_cyc"},  mon_rdc,             e.rdc);
          chk({e.name, "_pcwrite_cyc"},mon_pcwn,            e.pcwn);
        end
        mon_cyc = 0; mon_rdc = 0; mon_pcwn = 0; mon_alu_ex = 0;
      end
    end
  end

  // Driver: garbage opcode outside FETCH/DECODE, toggling ready outside memory states.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fwait,
                           input int mwait, input exp_t e);
    int fw = 0;
    int mw = 0;
    logic done = 1'b0;
    sb_q.push_back(e);
    for (int c = 0; c < 40 && !done; c++) begin
      if (state_o == 4'd0 || state_o == 4'd1) begin
        instr_op_i = op; instr_func_i = fn;
      end else begin
        instr_op_i = 6'b111111; instr_func_i = 6'b111111;
      end
      if (state_o == 4'd0) begin
        if (fw < fwait) begin mem_ready_i = 1'b0; fw++; end
        else mem_ready_i = 1'b1;
      end else if (state_o == 4'd7 || state_o == 4'd9) begin
        if (mw < mwait) begin mem_ready_i = 1'b0; mw++; end
        else mem_ready_i = 1'b1;
      end else begin
        mem_ready_i = c[0];
      end
      @(negedge clk);
      done = instr_done_o;
      @(posedge clk); #1;
    end
    chk({e.name, "_completed"}, int'(done), 1);
  endtask

  function automatic int enables();
    return int'(PCWrite_o) + int'(PCWriteCond_o) + int'(IRWrite_o) + int'(RegWrite_o)
         + int'(MemRead_o) + int'(MemWrite_o) + int'(instr_done_o);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; mem_ready_i = 1'b1; instr_op_i = 6'b101011; instr_func_i = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state",   int'(state_o),   0);
    chk("rst_illegal", int'(illegal_o), 0);
    chk("rst_enables", enables(),       0);
    chk("rst_ALUSrcB", int'(ALUSrcB_o), 0);

    // sw into MEM_WRITE with ready low, then reset mid-access.
    rst_i = 1'b0;
    @(posedge clk); #1; mem_ready_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midw_state",    int'(state_o),    9);
    chk("midw_MemWrite", int'(MemWrite_o), 1);
    #2 rst_i = 1'b1;
    #1;
    chk("midw_rst_MemWrite", int'(MemWrite_o), 0);
    chk("midw_rst_state",    int'(state_o),    0);
    chk("midw_rst_IorD",     int'(IorD_o),     0);
    @(posedge clk); #1;
    rst_i = 1'b0;

    run_instr(6'b000000, 6'b100000, 2, 0, mk("add_after_rst", 3, 6, 1, 1, 0, 0, 0, 0, 0, 0, 2, 0, 1));
    run_instr(6'b000000, 6'b100000, 0, 0, mk("add",   3, 4, 1, 1, 0, 0, 0, 0, 0, 0, 2, 0, 1));
    run_instr(6'b000000, 6'b011000, 0, 0, mk("mul",   3, 4, 1, 1, 0, 0, 0, 0, 0, 0, 2, 0, 1));
    run_instr(6'b100011, 6'b000000, 0, 3, mk("lw_w3", 8, 8, 1, 0, 1, 0, 0, 0, 0, 0, 5, 4, 1));
    run_instr(6'b100011, 6'b000000, 0, 0, mk("lw",    8, 5, 1, 0, 1, 0, 0, 0, 0, 0, 5, 1, 1));
    run_instr(6'b101011, 6'b000000, 0, 2, mk("sw_w2", 9, 6, 0, 0, 0, 0, 0, 0, 1, 0, 7, 0, 1));
    run_instr(6'b001000, 6'b000000, 0, 0, mk("addi",  5, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    run_instr(6'b001011, 6'b000000, 0, 0, mk("sltiu", 5, 4, 1, 0, 0, 0, 0, 0, 0, 0, 6, 0, 1));
    run_instr(6'b001101, 6'b000000, 0, 0, mk("ori",   5, 4, 1, 0, 0, 0, 0, 0, 0, 0, 4, 0, 1));
    run_instr(6'b001111, 6'b000000, 0, 0, mk("li",    5, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    run_instr(6'b000100, 6'b000000, 0, 0, mk("beq",  10, 3, 0, 0, 0, 1, 0, 1, 0, 1, 1, 0, 1));
    run_instr(6'b000101, 6'b000000, 0, 0, mk("bne",  10, 3, 0, 0, 0, 1, 3, 1, 0, 3, 3, 0, 1));
    run_instr(6'b000110, 6'b000000, 0, 0, mk("ble",  10, 3, 0, 0, 0, 1, 1, 1, 0, 8, 8, 0, 1));
    run_instr(6'b000001, 6'b000000, 0, 0, mk("bltz", 10, 3, 0, 0, 0, 1, 2, 1, 0, 10, 10, 0, 1));
    run_instr(6'b000010, 6'b000000, 0, 0, mk("j",    11, 3, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 2));
    run_instr(6'b000011, 6'b000000, 0, 0, mk("jal",  12, 3, 1, 2, 2, 2, 0, 0, 0, 9, 0, 0, 2));
    run_instr(6'b000000, 6'b001000, 0, 0, mk("jr",   13, 3, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 2));
    run_instr(6'b000000, 6'b100010, 3, 0, mk("sub_fw3", 3, 7, 1, 1, 0, 0, 0, 0, 0, 0, 2, 0, 1));

    // Illegal opcode traps and holds with no enables.
    instr_op_i = 6'b111111; instr_func_i = 6'd0; mem_ready_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ill_state",   int'(state_o),   14);
    chk("ill_illegal", int'(illegal_o), 1);
    for (int i = 0; i < 3; i++) begin
      mem_ready_i = i[0];
      instr_op_i  = 6'b000000;
      @(negedge clk);
      chk($sformatf("ill_hold_enables_%0d", i), enables(), 0);
      @(posedge clk); #1;
      chk($sformatf("ill_hold_state_%0d", i), int'(state_o), 14);
    end
    rst_i = 1'b1;
    #1;
    chk("ill_rst_illegal", int'(illegal_o), 0);
    @(posedge clk); #1;

    // FETCH timeout with MEM_WAIT_MAX = 4.
    mem_ready_i = 1'b0; instr_op_i = 6'b000000; instr_func_i = 6'b100000;
    rst_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("to_state_3waits", int'(state_o), 0);
    @(posedge clk); #1;
    chk("to_state_4waits", int'(state_o),   14);
    chk("to_illegal",      int'(illegal_o), 1);
    rst_i = 1'b1;
    @(posedge clk); #1;

    chk("sb_queue_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the MIPS datapath. One shared ALU and one unified instruction/data memory are reused across the cycles of each instruction.
- Decodes the opcode latched in the IR, then sequences fetch, decode, execute, memory and writeback.
- Drives all mux selects and write enables, stalls on the memory ready handshake and traps on illegal opcodes or memory timeout.
- Supported set: R-type (add, sub, and, or, slt, sra, srav, mul), jr, beq, bne, ble, bltz, addi, sltiu, ori, li, lw, sw, j, jal.

Parameters:
MEM_WAIT_MAX, 0, maximum wait cycles per memory access before trap; 0 = wait forever.
WAIT_W, 8, width of the wait counter.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
instr_op_i  in  6  IR[31:26]
instr_func_i  in  6  IR[5:0]
mem_ready_i  in  1  memory completes the current read/write this cycle
PCWrite_o  out  1  unconditional PC load
PCWriteCond_o  out  1  PC load if datapath branch condition is true
IorD_o  out  1  0 = memory address from PC, 1 = from ALUOut
MemRead_o  out  1  memory read request
MemWrite_o  out  1  memory write request
IRWrite_o  out  1  IR load
MemtoReg_o  out  2  0 = ALUOut, 1 = MDR, 2 = PC (link)
RegDst_o  out  2  0 = rt, 1 = rd, 2 = $31
RegWrite_o  out  1  register file write
ALUSrcA_o  out  1  0 = PC, 1 = reg A
ALUSrcB_o  out  2  0 = reg B, 1 = const 4, 2 = extended imm, 3 = sign-extended imm<<2
ALU_op_o  out  4  ALU_Ctrl op code
PCSource_o  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = reg A (jr)
BranchType_o  out  2  0 = beq, 1 = ble, 2 = bltz, 3 = bne
instr_done_o  out  1  one-cycle pulse on the last cycle of each instruction
illegal_o  out  1  sticky trap flag
state_o  out  4  current state, for debug

Behaviour:
- Reset: state = FETCH, wait counter 0, illegal_o 0.
- While rst_i = 1, all enables (PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite, instr_done) are forced 0 combinationally and all selects are 0. A reset mid-instruction aborts it with no further writes.
- Outputs are Moore on state, except the writes qualified by mem_ready_i noted below.
- Fields not listed for a state are 0.
- ALU_op codes: add 0000, beq 0001, R 0010, bne 0011, ori 0100, lw 0101, sltiu 0110, sw 0111, ble 1000, jal 1001, bltz 1010.
- States (encodings 0..14):
  - FETCH: MemRead 1, IorD 0, ALUSrcA 0, ALUSrcB 1, ALU_op 0000, PCSource 0. IRWrite and PCWrite assert only in the cycle mem_ready_i = 1; the FSM then goes to DECODE. Otherwise it stays.
  - DECODE: ALUSrcA 0, ALUSrcB 3, ALU_op 0000 (branch target into ALUOut). Next state by opcode:
    - 000000 with func 001000 -> JR; other 000000 -> R_EXEC.
    - 100011 or 101011 -> MEM_ADDR.
    - 000100, 000101, 000110, 000001 -> BRANCH.
    - 001000, 001011, 001101, 001111 -> I_EXEC.
    - 000010 -> JUMP; 000011 -> JAL.
    - Anything else -> TRAP.
  - R_EXEC: ALUSrcA 1, ALUSrcB 0, ALU_op 0010 -> R_WB.
  - R_WB: RegDst 1, MemtoReg 0, RegWrite 1, done -> FETCH.
  - I_EXEC: ALUSrcA 1, ALUSrcB 2, ALU_op = addi/li 0000, sltiu 0110, ori 0100 -> I_WB.
  - I_WB: RegDst 0, MemtoReg 0, RegWrite 1, done -> FETCH.
  - MEM_ADDR: ALUSrcA 1, ALUSrcB 2, ALU_op 0101 for lw / 0111 for sw -> MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ: MemRead 1, IorD 1. Held until mem_ready_i, then -> MEM_WB.
  - MEM_WB: RegDst 0, MemtoReg 1, RegWrite 1, done -> FETCH.
  - MEM_WRITE: MemWrite 1, IorD 1. Held until mem_ready_i; done fires in that cycle -> FETCH.
  - BRANCH: ALUSrcA 1, ALUSrcB 0, PCWriteCond 1, PCSource 1, done -> FETCH. ALU_op and BranchType by opcode:
    - beq: ALU_op 0001, BranchType 0.
    - bne: ALU_op 0011, BranchType 3.
    - ble: ALU_op 1000, BranchType 1.
    - bltz: ALU_op 1010, BranchType 2.
  - JUMP: PCWrite 1, PCSource 2, done -> FETCH.
  - JAL: PCWrite 1, PCSource 2, RegWrite 1, RegDst 2, MemtoReg 2, ALU_op 1001, done -> FETCH. The link value is the already-incremented PC.
  - JR: PCWrite 1, PCSource 3, done -> FETCH.
  - TRAP: all enables 0, illegal_o 1. Held until reset.
- Latency with mem_ready_i tied to 1: branch, j, jal, jr = 3 cycles; R, I, sw = 4 cycles; lw = 5 cycles. Each memory wait cycle adds 1.
- Wait counter:
  - Clears on entry to FETCH, MEM_READ and MEM_WRITE; increments each cycle mem_ready_i = 0 in those states.
  - If MEM_WAIT_MAX != 0 and the counter reaches MEM_WAIT_MAX with mem_ready_i still 0 -> TRAP. mem_ready_i = 1 in that same cycle wins.
  - The counter saturates; it never wraps.
- mem_ready_i outside FETCH, MEM_READ and MEM_WRITE is ignored.
- Opcode inputs are sampled only in DECODE. Changes in other states have no effect.

Decomposition:
- Package mc_ctrl_pkg: state encodings, opcode and func constants, ALU_op codes, and the PCSource, ALUSrcB, RegDst, MemtoReg and BranchType encodings.
- One sub-module, mc_ctrl_opdecode (combinational). Maps op/func to instruction class, execute ALU_op, BranchType and illegal. Used by DECODE, I_EXEC, MEM_ADDR and BRANCH.

Test Plan:
- Reset asserted mid MEM_WRITE with mem_ready_i = 0 -> MemWrite_o drops the same cycle; state_o = FETCH; after release, fetch restarts with PCWrite only on ready.
- add (op 000000, func 100000), ready = 1 -> states FETCH, DECODE, R_EXEC, R_WB. In R_WB: RegWrite 1, RegDst 1. instr_done pulses at cycle 4.
- lw with mem_ready_i low for 3 cycles in MEM_READ -> MemRead/IorD = 1 held 4 cycles; MEM_WB has MemtoReg 1; total 8 cycles.
- Branches: ble (000110) -> BRANCH with PCWriteCond 1, BranchType 1, ALU_op 1000. bltz (000001) -> BranchType 2, ALU_op 1010. Each takes 3 cycles.
- jal (000011) -> JAL with RegDst 2, MemtoReg 2, PCSource 2, RegWrite 1. jr (000000/001000) -> PCSource 3 with RegWrite 0.
- Opcode 111111 -> TRAP, illegal_o 1, no enables until reset. With MEM_WAIT_MAX = 4 and ready held 0 in FETCH -> TRAP after 4 wait cycles.
